// File: rtl/data_store_rx.sv
// Receive payload buffer: packs MSB-first beats into a 256-deep word store, tracks byte length
// and a folded ones'-complement sum, then replays the stored words as a burst on request.
module data_store_rx #(
    parameter int N         = 2,
    parameter int DATA_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 axiiv,
    input  logic [N-1:0]         axiid,
    input  logic                 axii_last,
    input  logic                 read_request,
    output logic                 axiov,
    output logic [DATA_SIZE-1:0] axiod,
    output logic                 axio_last,
    output logic                 frame_done,
    output logic [15:0]          data_sum,
    output logic [15:0]          data_length,
    output logic                 overflow
);
    localparam int BPW   = DATA_SIZE / N;
    localparam int BW    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DEPTH = 256;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_COMMIT, S_READY, S_READ} state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [DATA_SIZE-1:0] word_q, word_d;
    logic [8:0]           write_idx_q, write_idx_d;
    logic [15:0]          len_q, len_d;
    logic [2:0]           rem_q, rem_d;
    logic [15:0]          sum_q, sum_d;
    logic [15:0]          data_sum_q, data_sum_d;
    logic                 frame_done_q, frame_done_d;
    logic                 ovf_seen_q, ovf_seen_d;
    logic                 overflow_q, overflow_d;
    logic [7:0]           rd_addr_q, rd_addr_d;
    logic                 iss_v_q, iss_v_d, iss_last_q, iss_last_d;
    logic                 v1_q, v1_d, l1_q, l1_d;
    logic                 axiov_q, axiov_d, axio_last_q, axio_last_d;
    logic [DATA_SIZE-1:0] axiod_q, axiod_d;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [DATA_SIZE-1:0] mem_dout_q;
    logic                 wr_en;
    logic [7:0]           wr_addr;
    logic [DATA_SIZE-1:0] wr_data;

    logic [DATA_SIZE-1:0] beat_ext, word_next;
    logic [7:0]           beat_sh;
    logic                 accept, drop, word_full, clear_frame;
    logic                 add_v;
    logic [15:0]          add_val, commit_val, sum_in, sum_folded;
    logic [16:0]          sum_raw;

    assign beat_ext    = DATA_SIZE'(axiid);
    assign beat_sh     = 8'((BPW - 1 - int'(beat_q)) * N);
    assign word_next   = word_q | (beat_ext << beat_sh);
    // Word 256 does not exist, so any beat arriving with a full store is dropped.
    assign accept      = axiiv && (state_q == S_IDLE || state_q == S_FILL) && !write_idx_q[8];
    assign drop        = axiiv && !accept;
    assign word_full   = accept && (beat_q == BW'(BPW - 1));
    assign clear_frame = (state_q == S_READ && l1_q) ||
                         (state_q == S_READY && read_request && write_idx_q == 9'd0);

    assign sum_in     = (state_q == S_COMMIT) ? commit_val : add_val;
    assign sum_raw    = {1'b0, sum_q} + {1'b0, sum_in};
    assign sum_folded = sum_raw[15:0] + {15'd0, sum_raw[16]};

    generate
        if (DATA_SIZE == 16) begin : g_sum16
            assign add_v      = word_full;
            assign add_val    = word_next;
            assign commit_val = (int'(beat_q) * N >= 8) ? {word_q[DATA_SIZE-1 -: 8], 8'h00} : 16'h0000;
        end else begin : g_sum8
            // Bytes pair up high:low; the first byte of a pair waits in hi_q.
            logic       pend_q, pend_d;
            logic [7:0] hi_q, hi_d;
            always_comb begin
                pend_d = pend_q;
                hi_d   = hi_q;
                if (clear_frame || state_q == S_COMMIT) begin
                    pend_d = 1'b0;
                end else if (word_full) begin
                    pend_d = !pend_q;
                    if (!pend_q) hi_d = word_next[7:0];
                end
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_q <= 1'b0;
                    hi_q   <= 8'h00;
                end else begin
                    pend_q <= pend_d;
                    hi_q   <= hi_d;
                end
            end
            assign add_v      = word_full && pend_q;
            assign add_val    = {hi_q, word_next[7:0]};
            assign commit_val = pend_q ? {hi_q, 8'h00} : 16'h0000;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        word_d       = word_q;
        write_idx_d  = write_idx_q;
        len_d        = len_q;
        rem_d        = rem_q;
        sum_d        = sum_q;
        data_sum_d   = data_sum_q;
        frame_done_d = frame_done_q;
        ovf_seen_d   = ovf_seen_q | drop;
        overflow_d   = drop && !ovf_seen_q;
        rd_addr_d    = rd_addr_q;
        iss_v_d      = iss_v_q;
        iss_last_d   = iss_last_q;
        wr_en        = 1'b0;
        wr_addr      = write_idx_q[7:0];
        wr_data      = word_next;
        v1_d         = iss_v_q;
        l1_d         = iss_v_q && iss_last_q;
        axiov_d      = v1_q;
        axio_last_d  = l1_q;
        axiod_d      = v1_q ? mem_dout_q : '0;

        if (accept) begin
            {len_d, rem_d} = {len_q, rem_q} + 19'(N);
            if (word_full) begin
                wr_en       = 1'b1;
                write_idx_d = write_idx_q + 9'd1;
                word_d      = '0;
                beat_d      = '0;
            end else begin
                word_d = word_next;
                beat_d = beat_q + BW'(1);
            end
        end
        if (state_q == S_COMMIT || add_v) sum_d = sum_folded;

        case (state_q)
            S_IDLE: if (axiiv) begin
                state_d = axii_last ? S_COMMIT : S_FILL;
                if (axii_last) ovf_seen_d = 1'b0;
            end
            S_FILL: if (axiiv && axii_last) begin
                state_d    = S_COMMIT;
                ovf_seen_d = 1'b0;
            end
            S_COMMIT: begin
                if (beat_q != '0) begin
                    wr_en       = 1'b1;
                    wr_data     = word_q;
                    write_idx_d = write_idx_q + 9'd1;
                    beat_d      = '0;
                    word_d      = '0;
                end
                data_sum_d   = sum_folded;
                frame_done_d = 1'b1;
                state_d      = S_READY;
            end
            S_READY: if (read_request) begin
                if (write_idx_q == 9'd0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_READ;
                    rd_addr_d  = 8'd0;
                    iss_v_d    = 1'b1;
                    iss_last_d = (write_idx_q == 9'd1);
                end
            end
            S_READ: begin
                if (iss_v_q) begin
                    if (iss_last_q) begin
                        iss_v_d    = 1'b0;
                        iss_last_d = 1'b0;
                    end else begin
                        rd_addr_d  = rd_addr_q + 8'd1;
                        iss_last_d = ({1'b0, rd_addr_q} + 9'd2 == write_idx_q);
                    end
                end
                if (l1_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear_frame) begin
            write_idx_d  = 9'd0;
            len_d        = 16'd0;
            rem_d        = 3'd0;
            sum_d        = 16'd0;
            data_sum_d   = 16'd0;
            frame_done_d = 1'b0;
            ovf_seen_d   = 1'b0;
        end
    end

    // Word store: no reset, registered read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        mem_dout_q <= mem[rd_addr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            word_q       <= '0;
            write_idx_q  <= 9'd0;
            len_q        <= 16'd0;
            rem_q        <= 3'd0;
            sum_q        <= 16'd0;
            data_sum_q   <= 16'd0;
            frame_done_q <= 1'b0;
            ovf_seen_q   <= 1'b0;
            overflow_q   <= 1'b0;
            rd_addr_q    <= 8'd0;
            iss_v_q      <= 1'b0;
            iss_last_q   <= 1'b0;
            v1_q         <= 1'b0;
            l1_q         <= 1'b0;
            axiov_q      <= 1'b0;
            axio_last_q  <= 1'b0;
            axiod_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            word_q       <= word_d;
            write_idx_q  <= write_idx_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            sum_q        <= sum_d;
            data_sum_q   <= data_sum_d;
            frame_done_q <= frame_done_d;
            ovf_seen_q   <= ovf_seen_d;
            overflow_q   <= overflow_d;
            rd_addr_q    <= rd_addr_d;
            iss_v_q      <= iss_v_d;
            iss_last_q   <= iss_last_d;
            v1_q         <= v1_d;
            l1_q         <= l1_d;
            axiov_q      <= axiov_d;
            axio_last_q  <= axio_last_d;
            axiod_q      <= axiod_d;
        end
    end

    assign axiov       = axiov_q;
    assign axiod       = axiod_q;
    assign axio_last   = axio_last_q;
    assign frame_done  = frame_done_q;
    assign data_sum    = data_sum_q;
    assign data_length = len_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_data_store_rx.sv
// Randomised and directed bench for data_store_rx (N=2, DATA_SIZE=16) against a bit-level model.
module tb_data_store_rx;
    localparam int N  = 2;
    localparam int DS = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          axiiv = 1'b0;
    logic [N-1:0]  axiid = '0;
    logic          axii_last = 1'b0;
    logic          read_request = 1'b0;
    logic          axiov;
    logic [DS-1:0] axiod;
    logic          axio_last;
    logic          frame_done;
    logic [15:0]   data_sum;
    logic [15:0]   data_length;
    logic          overflow;

    data_store_rx #(.N(N), .DATA_SIZE(DS)) dut (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv), .axiid(axiid), .axii_last(axii_last),
        .read_request(read_request), .axiov(axiov), .axiod(axiod), .axio_last(axio_last),
        .frame_done(frame_done), .data_sum(data_sum), .data_length(data_length),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ovf_cnt = 0;
    always @(negedge clk) if (overflow === 1'b1) ovf_cnt++;

    logic [1:0]  beats[$];
    logic [15:0] exp_words[$];
    int          exp_len;
    logic [15:0] exp_sum;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        for (int b = 7; b >= 0; b--) beats.push_back(w[b*2 +: 2]);
    endtask

    // Model: flatten the beat stream to bits, cap at store capacity, slice into words,
    // count whole bytes and sum big-endian byte pairs with a final end-around fold.
    task automatic build_expect();
        bit          bq[$];
        int          nbits;
        int          s;
        int          hi;
        int          lo;
        logic [15:0] v;
        foreach (beats[i]) begin
            bq.push_back(beats[i][1]);
            bq.push_back(beats[i][0]);
        end
        nbits = bq.size();
        if (nbits > 256 * DS) nbits = 256 * DS;
        exp_words.delete();
        for (int w = 0; w * DS < nbits; w++) begin
            v = '0;
            for (int b = 0; b < DS; b++)
                v = {v[14:0], (w * DS + b < nbits) ? bq[w*DS+b] : 1'b0};
            exp_words.push_back(v);
        end
        exp_len = nbits / 8;
        s = 0;
        for (int p = 0; p < exp_len; p += 2) begin
            hi = 0;
            lo = 0;
            for (int k = 0; k < 8; k++) hi = hi * 2 + int'(bq[p*8+k]);
            if (p + 1 < exp_len)
                for (int k = 0; k < 8; k++) lo = lo * 2 + int'(bq[(p+1)*8+k]);
            s += hi * 256 + lo;
        end
        while (s > 65535) s = (s & 65535) + (s >> 16);
        exp_sum = 16'(s);
    endtask

    task automatic send_frame(input int maxgap);
        int gap;
        for (int i = 0; i < beats.size(); i++) begin
            gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (gap) begin
                axiiv     = 1'b0;
                axiid     = 2'($urandom);
                axii_last = 1'($urandom);
                tick();
            end
            axiiv     = 1'b1;
            axiid     = beats[i];
            axii_last = (i == beats.size() - 1);
            tick();
        end
        axiiv     = 1'b0;
        axii_last = 1'b0;
    endtask

    task automatic do_replay(input string name, input bit with_beat);
        int n;
        n = exp_words.size();
        read_request = 1'b1;
        if (with_beat) begin
            axiiv = 1'b1;
            axiid = 2'($urandom);
        end
        tick();
        read_request = 1'b0;
        axiiv        = 1'b0;
        if (with_beat) begin
            checks++;
            if (overflow !== 1'b1) begin
                failures++;
                $display("FAIL %s_start_drop overflow=%b expected 1", name, overflow);
            end
        end
        for (int c = 1; c <= n + 2; c++) begin
            tick();
            if (c == 1 || c == n + 2) begin
                checks++;
                if (axiov !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_idle_cycle%0d axiov=%b expected 0", name, c, axiov);
                end
            end else begin
                checks++;
                if (axiov !== 1'b1 || axiod !== exp_words[c-2] || axio_last !== (c == n + 1)) begin
                    failures++;
                    $display("FAIL %s_word%0d got v=%b d=%h last=%b expected v=1 d=%h last=%b",
                             name, c - 2, axiov, axiod, axio_last, exp_words[c-2], (c == n + 1));
                end
            end
            if (c == n + 1) begin
                checks++;
                if (frame_done !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_done_drop frame_done=%b expected 0", name, frame_done);
                end
            end
            if (c == n + 2) begin
                checks++;
                if (data_length !== 16'd0 || data_sum !== 16'd0) begin
                    failures++;
                    $display("FAIL %s_cleared len=%0d sum=%h expected 0 0", name, data_length, data_sum);
                end
            end
        end
    endtask

    task automatic finish_frame(input string name, input bit with_beat);
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL %s_commit_done frame_done=%b expected 0", name, frame_done);
        end
        tick();
        checks++;
        if (frame_done !== 1'b1 || data_length !== 16'(exp_len) || data_sum !== exp_sum) begin
            failures++;
            $display("FAIL %s_result done=%b len=%0d sum=%h expected done=1 len=%0d sum=%h",
                     name, frame_done, data_length, data_sum, exp_len, exp_sum);
        end
        do_replay(name, with_beat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({axiov, axiod, axio_last, frame_done, data_sum, data_length, overflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs v=%b d=%h l=%b done=%b sum=%h len=%0d ovf=%b expected all 0",
                     axiov, axiod, axio_last, frame_done, data_sum, data_length, overflow);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        beats.delete();
        push_word(16'hABCD);
        send_frame(0);
        exp_words = '{16'hABCD};
        exp_len   = 2;
        exp_sum   = 16'hABCD;
        finish_frame("basic", 1'b0);
    endtask

    task automatic test_carry();
        beats.delete();
        push_word(16'hFFFF);
        push_word(16'h0001);
        send_frame(1);
        exp_words = '{16'hFFFF, 16'h0001};
        exp_len   = 4;
        exp_sum   = 16'h0001;
        finish_frame("carry", 1'b0);
    endtask

    task automatic test_partial();
        beats.delete();
        push_word(16'h1234);
        beats.push_back(2'b01);
        beats.push_back(2'b01);
        beats.push_back(2'b01);
        beats.push_back(2'b10);
        send_frame(0);
        exp_words = '{16'h1234, 16'h5600};
        exp_len   = 3;
        exp_sum   = 16'h6834;
        finish_frame("partial", 1'b0);
    endtask

    task automatic test_back_to_back();
        int start;
        beats.delete();
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        send_frame(0);
        exp_words = '{16'h1111, 16'h2222, 16'h3333};
        exp_len   = 6;
        exp_sum   = 16'h6666;
        start     = ovf_cnt;
        finish_frame("three_words", 1'b1);
        checks++;
        if (ovf_cnt - start !== 1) begin
            failures++;
            $display("FAIL three_words_ovf_count got=%0d expected 1", ovf_cnt - start);
        end
    endtask

    task automatic test_drop_ready();
        beats.delete();
        push_word(16'hABCD);
        send_frame(0);
        exp_words = '{16'hABCD};
        exp_len   = 2;
        exp_sum   = 16'hABCD;
        tick();
        axiiv     = 1'b1;
        axiid     = 2'b11;
        axii_last = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ready_drop_first overflow=%b expected 1", overflow);
        end
        tick();
        axiiv     = 1'b0;
        axii_last = 1'b0;
        checks++;
        if (overflow !== 1'b0 || frame_done !== 1'b1 || data_length !== 16'd2) begin
            failures++;
            $display("FAIL ready_drop_second ovf=%b done=%b len=%0d expected 0 1 2",
                     overflow, frame_done, data_length);
        end
        do_replay("ready_drop", 1'b0);
    endtask

    task automatic test_random();
        int start;
        int nb;
        for (int f = 0; f < 20; f++) begin
            beats.delete();
            nb = int'($urandom_range(60, 1));
            for (int i = 0; i < nb; i++) beats.push_back(2'($urandom));
            build_expect();
            start = ovf_cnt;
            send_frame(2);
            finish_frame($sformatf("rand%0d", f), 1'b0);
            checks++;
            if (ovf_cnt !== start) begin
                failures++;
                $display("FAIL rand%0d_no_overflow pulses=%0d expected 0", f, ovf_cnt - start);
            end
        end
    endtask

    task automatic test_overflow();
        int start;
        beats.delete();
        for (int w = 0; w < 257; w++) push_word(16'($urandom));
        build_expect();
        start = ovf_cnt;
        for (int i = 0; i < beats.size(); i++) begin
            axiiv     = 1'b1;
            axiid     = beats[i];
            axii_last = (i == beats.size() - 1);
            tick();
            if (i == 256 * 8) begin
                checks++;
                if (overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_pulse_at_word257 overflow=%b expected 1", overflow);
                end
            end
        end
        axiiv     = 1'b0;
        axii_last = 1'b0;
        checks++;
        if (ovf_cnt - start !== 1) begin
            failures++;
            $display("FAIL ovf_single_pulse got=%0d expected 1", ovf_cnt - start);
        end
        checks++;
        if (exp_words.size() !== 256 || exp_len !== 512) begin
            failures++;
            $display("FAIL ovf_model_cap words=%0d len=%0d expected 256 512", exp_words.size(), exp_len);
        end
        finish_frame("overflow", 1'b0);
    endtask

    task automatic test_reset_midfill();
        beats.delete();
        for (int i = 0; i < 5; i++) beats.push_back(2'b10);
        for (int i = 0; i < 5; i++) begin
            axiiv = 1'b1;
            axiid = beats[i];
            tick();
        end
        axiiv = 1'b0;
        checks++;
        if (data_length !== 16'd1) begin
            failures++;
            $display("FAIL midfill_length len=%0d expected 1", data_length);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({axiov, axiod, axio_last, frame_done, data_sum, data_length, overflow} !== '0) begin
            failures++;
            $display("FAIL midfill_reset_outputs done=%b sum=%h len=%0d ovf=%b expected all 0",
                     frame_done, data_sum, data_length, overflow);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        beats.delete();
        push_word(16'hABCD);
        send_frame(0);
        exp_words = '{16'hABCD};
        exp_len   = 2;
        exp_sum   = 16'hABCD;
        finish_frame("after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_partial();
        test_back_to_back();
        test_drop_ready();
        test_random();
        test_overflow();
        test_reset_midfill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
